// File: rtl/pmod_clp_pkg.sv
// Shared types, init ROM and opcode constants for the PmodCLP bus sequencer.
package pmod_clp_pkg;

   // Bus sequencer states
   typedef enum logic [2:0] {
      ST_PWRUP     = 3'd0,
      ST_INIT_LOAD = 3'd1,
      ST_SETUP     = 3'd2,
      ST_E_HIGH    = 3'd3,
      ST_HOLD      = 3'd4,
      ST_WAIT      = 3'd5,
      ST_IDLE      = 3'd6
   } state_e;

   // Execution-wait classes applied after each E pulse
   typedef enum logic [1:0] {
      WC_EXEC  = 2'd0,
      WC_LONG  = 2'd1,
      WC_INIT1 = 2'd2,
      WC_INIT2 = 2'd3
   } wait_cls_e;

   // One init ROM entry: instruction byte plus the wait that follows it
   typedef struct packed {
      logic [7:0] data;
      wait_cls_e  cls;
   } init_entry_t;

   localparam int unsigned INIT_LEN   = 7;
   localparam int unsigned INIT_IDX_W = 3;

   localparam logic [7:0] OP_CLEAR = 8'h01;
   localparam logic [7:0] OP_HOME  = 8'h02;

   // Power-up init ROM: function set x4, display on, clear, entry mode
   function automatic init_entry_t init_rom(input logic [INIT_IDX_W-1:0] idx);
      init_entry_t e;
      e.data = 8'h00;
      e.cls  = WC_EXEC;
      case (idx)
         3'd0:    begin e.data = 8'h38; e.cls = WC_INIT1; end
         3'd1:    begin e.data = 8'h38; e.cls = WC_INIT2; end
         3'd2:    begin e.data = 8'h38; e.cls = WC_EXEC;  end
         3'd3:    begin e.data = 8'h38; e.cls = WC_EXEC;  end
         3'd4:    begin e.data = 8'h0C; e.cls = WC_EXEC;  end
         3'd5:    begin e.data = OP_CLEAR; e.cls = WC_LONG; end
         3'd6:    begin e.data = 8'h06; e.cls = WC_EXEC;  end
         default: begin e.data = 8'h00; e.cls = WC_EXEC;  end
      endcase
      return e;
   endfunction

   // Larger of two cycle counts, used to size the phase timer
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pmod_clp_bus_ctrl_timer.sv
// Loadable phase down-counter; a zero load value counts as one cycle.
module lcd_wait_timer #(
   parameter int unsigned W       = 8,
   parameter int unsigned RST_VAL = 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_expired
);

   localparam logic [W-1:0] RST_EFF = (RST_VAL == 0) ? W'(1) : W'(RST_VAL);

   logic [W-1:0] r_cnt;
   logic         r_expired;
   logic [W-1:0] w_load_eff;

   assign w_load_eff = (i_load_val == '0) ? W'(1) : i_load_val;

   // Count down to 1 and stop; expired is high in the last cycle of the phase
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt     <= RST_EFF;
         r_expired <= (RST_EFF == W'(1));
      end else if (i_load) begin
         r_cnt     <= w_load_eff;
         r_expired <= (w_load_eff == W'(1));
      end else if (r_cnt > W'(1)) begin
         r_cnt     <= r_cnt - W'(1);
         r_expired <= (r_cnt == W'(2));
      end
   end

   assign o_expired = r_expired;

endmodule

// File: rtl/pmod_clp_bus_ctrl.sv
// PmodCLP (HD44780) parallel-bus sequencer: power-up init, then one byte write per handshake.
module pmod_clp_bus_ctrl
   import pmod_clp_pkg::*;
#(
   parameter int unsigned T_SETUP_CYC = 4,
   parameter int unsigned T_EPW_CYC   = 25,
   parameter int unsigned T_HOLD_CYC  = 2,
   parameter int unsigned T_EXEC_CYC  = 3700,
   parameter int unsigned T_LONG_CYC  = 152000,
   parameter int unsigned T_PWRUP_CYC = 2000000,
   parameter int unsigned T_INIT1_CYC = 410000,
   parameter int unsigned T_INIT2_CYC = 10000
) (
   input  logic       sysclk,
   input  logic       sysreset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rs,
   input  logic [7:0] cmd_data,
   output logic       init_done,
   output logic       busy,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e
);

   localparam int unsigned T_MAX = max_u(max_u(max_u(T_SETUP_CYC, T_EPW_CYC),
                                               max_u(T_HOLD_CYC, T_EXEC_CYC)),
                                         max_u(max_u(T_LONG_CYC, T_PWRUP_CYC),
                                               max_u(T_INIT1_CYC, T_INIT2_CYC)));
   localparam int unsigned TMR_W = $clog2(T_MAX) + 1;

   localparam logic [TMR_W-1:0] L_SETUP = TMR_W'(T_SETUP_CYC);
   localparam logic [TMR_W-1:0] L_EPW   = TMR_W'(T_EPW_CYC);
   localparam logic [TMR_W-1:0] L_HOLD  = TMR_W'(T_HOLD_CYC);
   localparam logic [TMR_W-1:0] L_EXEC  = TMR_W'(T_EXEC_CYC);
   localparam logic [TMR_W-1:0] L_LONG  = TMR_W'(T_LONG_CYC);
   localparam logic [TMR_W-1:0] L_INIT1 = TMR_W'(T_INIT1_CYC);
   localparam logic [TMR_W-1:0] L_INIT2 = TMR_W'(T_INIT2_CYC);

   localparam logic [INIT_IDX_W-1:0] LAST_IDX = INIT_IDX_W'(INIT_LEN - 1);

   state_e                r_state;
   logic [INIT_IDX_W-1:0] r_init_idx;
   logic                  r_init_done;
   logic                  r_cmd_ready;
   logic                  r_busy;
   logic [7:0]            r_lcd_data;
   logic                  r_lcd_rs;
   logic                  r_lcd_e;

   logic                  w_accept;
   logic                  w_expired;
   logic                  w_tmr_load;
   logic [TMR_W-1:0]      w_tmr_val;
   logic [TMR_W-1:0]      w_wait_val;
   wait_cls_e             w_wait_cls;
   init_entry_t           w_rom;

   assign w_accept = cmd_valid && r_cmd_ready;
   assign w_rom    = init_rom(r_init_idx);

   // Wait class for the byte on the bus: ROM-defined during init, opcode decode afterwards
   always_comb begin
      w_wait_cls = WC_EXEC;
      if (!r_init_done) begin
         w_wait_cls = w_rom.cls;
      end else if (!r_lcd_rs && ((r_lcd_data == OP_CLEAR) ||
                                 (r_lcd_data[7:1] == OP_HOME[7:1]))) begin
         w_wait_cls = WC_LONG;
      end
   end

   // Map wait class to its cycle count
   always_comb begin
      w_wait_val = L_EXEC;
      case (w_wait_cls)
         WC_LONG:  w_wait_val = L_LONG;
         WC_INIT1: w_wait_val = L_INIT1;
         WC_INIT2: w_wait_val = L_INIT2;
         default:  w_wait_val = L_EXEC;
      endcase
   end

   // Reload the phase timer on every timed-phase entry
   always_comb begin
      w_tmr_load = 1'b0;
      w_tmr_val  = '0;
      case (r_state)
         ST_INIT_LOAD: begin
            w_tmr_load = 1'b1;
            w_tmr_val  = L_SETUP;
         end
         ST_IDLE: begin
            w_tmr_load = w_accept;
            w_tmr_val  = L_SETUP;
         end
         ST_SETUP: begin
            w_tmr_load = w_expired;
            w_tmr_val  = L_EPW;
         end
         ST_E_HIGH: begin
            w_tmr_load = w_expired;
            w_tmr_val  = L_HOLD;
         end
         ST_HOLD: begin
            w_tmr_load = w_expired;
            w_tmr_val  = w_wait_val;
         end
         default: ;
      endcase
   end

   lcd_wait_timer #(
      .W       (TMR_W),
      .RST_VAL (T_PWRUP_CYC)
   ) u_timer (
      .i_clk      (sysclk),
      .i_rst_n    (sysreset_n),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_expired  (w_expired)
   );

   // Bus sequencer with registered bus, strobe and handshake outputs
   always_ff @(posedge sysclk or negedge sysreset_n) begin
      if (!sysreset_n) begin
         r_state     <= ST_PWRUP;
         r_init_idx  <= '0;
         r_init_done <= 1'b0;
         r_cmd_ready <= 1'b0;
         r_busy      <= 1'b1;
         r_lcd_data  <= 8'h00;
         r_lcd_rs    <= 1'b0;
         r_lcd_e     <= 1'b0;
      end else begin
         case (r_state)
            ST_PWRUP: begin
               if (w_expired) r_state <= ST_INIT_LOAD;
            end
            ST_INIT_LOAD: begin
               r_lcd_rs   <= 1'b0;
               r_lcd_data <= w_rom.data;
               r_state    <= ST_SETUP;
            end
            ST_SETUP: begin
               if (w_expired) begin
                  r_lcd_e <= 1'b1;
                  r_state <= ST_E_HIGH;
               end
            end
            ST_E_HIGH: begin
               if (w_expired) begin
                  r_lcd_e <= 1'b0;
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (w_expired) r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_expired) begin
                  if (r_init_done || (r_init_idx == LAST_IDX)) begin
                     r_init_done <= 1'b1;
                     r_init_idx  <= '0;
                     r_cmd_ready <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= ST_IDLE;
                  end else begin
                     r_init_idx <= r_init_idx + INIT_IDX_W'(1);
                     r_state    <= ST_INIT_LOAD;
                  end
               end
            end
            ST_IDLE: begin
               if (w_accept) begin
                  r_lcd_rs    <= cmd_rs;
                  r_lcd_data  <= cmd_data;
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= ST_SETUP;
               end
            end
            default: r_state <= ST_PWRUP;
         endcase
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign init_done = r_init_done;
   assign busy      = r_busy;
   assign lcd_data  = r_lcd_data;
   assign lcd_rs    = r_lcd_rs;
   assign lcd_rw    = 1'b0;
   assign lcd_e     = r_lcd_e;

endmodule
